// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop), folds E0/F0 prefixes into flags, and queues the resulting key
//   events in a first-word-fall-through FIFO.
//
//   Optional build macro: PS2_PARITY_CHECK_EN
//     defined   : frames with even parity are dropped and parity_err pulses
//     undefined : the parity bit is consumed and ignored, parity_err is 0
//
// Parameters
//   FILTER_LEN  : equal synchronized clk_kb samples needed to move the
//                 filtered keyboard clock
//   FIFO_DEPTH  : key event entries (power of two, >= 2)
//   TIMEOUT_CYC : idle cycles inside a frame before it is aborted
//
// Ports
//   clock, reset         : system clock, async active-low reset
//   clk_kb, data_kb      : raw PS/2 lines (asynchronous)
//   key_code/ext/break   : FIFO head entry, all zero when empty
//   key_valid, key_ready : head handshake; pop when both high
//   fifo_count           : stored entries
//   overflow             : pulse, event dropped on a full FIFO
//   frame_err            : pulse, bad stop bit or frame timeout
//   parity_err           : pulse, parity failure (checked builds only)
module ps2_key_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clk_kb,
  input  logic                          data_kb,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_entry_t;

  // ---------------------------------------------------------------------
  // Synchronizers and clock filter
  // ---------------------------------------------------------------------
  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d, filt_dly_q;
  logic                  fall;

  always_comb begin
    // Window of the last FILTER_LEN synchronized samples, newest in bit 0.
    hist_d = (hist_q << 1) | FILTER_LEN'(clk_s2_q);
    filt_d = filt_q;
    if (&hist_d)       filt_d = 1'b1;
    else if (~|hist_d) filt_d = 1'b0;
  end

  assign fall = ~filt_q & filt_dly_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      hist_q     <= '1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
    end else begin
      clk_s1_q   <= clk_kb;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= data_kb;
      dat_s2_q   <= dat_s1_q;
      hist_q     <= hist_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          rx_vld_q, rx_vld_d;
  logic          frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
  logic          parity_err_q, parity_err_d;
`endif

  // tmo_q counts edge-free cycles since the last edge, so it reads k-1 in the
  // k-th such cycle; the abort fires in the TIMEOUT_CYC-th one.
  assign tmo_hit = (state_q != IDLE) && !fall &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_vld_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d   = DATA;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!dat_s2_q) frame_err_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (~^{shift_q, par_q}) parity_err_d = 1'b1;
`endif
          else rx_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Prefix decode. Runs in the cycle after the stop bit; shift_q still holds
  // the byte because no new start bit can be filtered in that cycle.
  // ---------------------------------------------------------------------
  logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic       push;
  key_entry_t push_entry;

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    push_entry = {ext_pend_q, brk_pend_q, shift_q};
    if (rx_vld_q) begin
      if (shift_q == 8'hF0)      brk_pend_d = 1'b1;
      else if (shift_q == 8'hE0) ext_pend_d = 1'b1;
      else begin
        push       = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  // ---------------------------------------------------------------------
  // Key event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  key_entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                full, pop, do_push;
  logic                overflow_q, overflow_d;
  key_entry_t          head;

  assign key_valid = (cnt_q != '0);
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = push && full && !pop;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are gated by key_valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign key_code   = key_valid ? head.code : 8'h00;
  assign key_ext    = key_valid & head.ext;
  assign key_break  = key_valid & head.brk;
  assign fifo_count = cnt_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q | tmo_hit;

endmodule

// File: tb/tb_ps2_key_fifo.sv
`timescale 1ns/1ps
module tb_ps2_key_fifo;
  localparam int FL = 4;    // FILTER_LEN
  localparam int FD = 4;    // FIFO_DEPTH
  localparam int TO = 300;  // TIMEOUT_CYC
  localparam int H  = 10;   // half PS/2 bit period in system cycles
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b0;
  logic       clk_kb = 1'b1, data_kb = 1'b1, key_ready = 1'b0;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid, overflow, frame_err, parity_err;
  logic [2:0] fifo_count;

  ps2_key_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .clk_kb(clk_kb), .data_kb(data_kb),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .key_ready(key_ready), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // pulse monitors, sampled away from the active edge
  int   n_ovf = 0, n_ferr = 0, n_perr = 0, kv_rise = 0, ferr_cyc = 0;
  logic kv_prev = 1'b0;
  always @(negedge clock) begin
    kv_prev <= key_valid;
    if (key_valid && !kv_prev) kv_rise <= cyc;
    if (overflow)   n_ovf  <= n_ovf + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
  end

  int n_chk = 0, n_pass = 0, last_fall = 0;
  logic [9:0] sb[$];   // {ext, brk, code}

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    data_kb = b;
    tick(H/2);
    clk_kb = 1'b0;
    last_fall = cyc;
    tick(H);
    clk_kb = 1'b1;
    tick(H/2);
  endtask

  // pop_at_push raises key_ready for exactly the cycle the entry is written
  // (stop-bit edge cycle + 1 = FL+3 cycles after the stop-bit fall is driven).
  task automatic send_frame(input logic [7:0] b, input logic badp,
                            input logic stop, input logic pop_at_push);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ badp);
    if (!pop_at_push) send_bit(stop);
    else begin
      data_kb = stop;
      tick(H/2);
      clk_kb = 1'b0;
      last_fall = cyc;
      tick(FL + 3);
      key_ready = 1'b1;
      if (sb.size() > 0) chk("simul pop head", key_code, sb.pop_front());
      tick(1);
      key_ready = 1'b0;
      tick(H - FL - 4);
      clk_kb = 1'b1;
      tick(H/2);
    end
    data_kb = 1'b1;
    tick(H);
  endtask

  task automatic pop_check(input string nm);
    logic [9:0] e;
    int w;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
      return;
    end
    e = sb.pop_front();
    w = 0;
    while (!key_valid && w < 50) begin tick(1); w++; end
    chk({nm, " valid"}, key_valid, 1);
    chk({nm, " code"},  key_code,  e[7:0]);
    chk({nm, " ext"},   key_ext,   e[9]);
    chk({nm, " break"}, key_break, e[8]);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]      nb;
    logic [2:0][7:0] b;
    logic            badp;   // corrupt parity of the last byte
    logic            push;
    logic [9:0]      exp;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [7:0] b0, b1, b2,
                              input logic badp, push, ext, brk,
                              input logic [7:0] code);
    vec_t v;
    v.nb = 2'(nb); v.b = {b2, b1, b0}; v.badp = badp; v.push = push;
    v.exp = {ext, brk, code};
    return v;
  endfunction

  vec_t vt [9];
  int base_o, base_f, base_p;

  initial begin
    vt[0] = mk(1, 8'h1C, 8'h00, 8'h00, 0, 1,    0, 0,   8'h1C);
    vt[1] = mk(2, 8'hF0, 8'h1C, 8'h00, 0, 1,    0, 1,   8'h1C);
    vt[2] = mk(3, 8'hE0, 8'hF0, 8'h75, 0, 1,    1, 1,   8'h75);
    vt[3] = mk(1, 8'h75, 8'h00, 8'h00, 0, 1,    0, 0,   8'h75);
    vt[4] = mk(2, 8'hE0, 8'h6B, 8'h00, 0, 1,    1, 0,   8'h6B);
    vt[5] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 1,    0, 0,   8'hFF);
    vt[6] = mk(1, 8'h1C, 8'h00, 8'h00, 1, !PAR, 0, 0,   8'h1C);
    vt[7] = mk(2, 8'hF0, 8'h5A, 8'h00, 1, !PAR, 0, 1,   8'h5A);
    // checked build keeps the F0 from the dropped frame pending
    vt[8] = mk(1, 8'h5A, 8'h00, 8'h00, 0, 1,    0, PAR, 8'h5A);

    // reset state
    tick(3);
    chk("rst key_valid", key_valid, 0);
    chk("rst key_code", key_code, 0);
    chk("rst ext/brk", {key_ext, key_break}, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst pulses", {overflow, frame_err, parity_err}, 0);
    reset = 1'b1;
    tick(5);

    // table-driven frames
    for (int i = 0; i < 9; i++) begin
      base_p = n_perr;
      for (int j = 0; j < int'(vt[i].nb); j++)
        send_frame(vt[i].b[j], (j == int'(vt[i].nb) - 1) && vt[i].badp, 1'b1, 1'b0);
      if (vt[i].push) sb.push_back(vt[i].exp);
      tick(2);
      chk($sformatf("v%0d parity_err", i), n_perr - base_p, (PAR && vt[i].badp) ? 1 : 0);
      if (vt[i].push) begin
        chk($sformatf("v%0d latency", i), kv_rise - last_fall, FL + 4);
        chk($sformatf("v%0d count", i), fifo_count, 1);
        pop_check($sformatf("v%0d", i));
        chk($sformatf("v%0d empty valid", i), key_valid, 0);
        chk($sformatf("v%0d empty code", i), key_code, 0);
      end else begin
        chk($sformatf("v%0d no push", i), fifo_count, 0);
      end
    end

    // bad stop bit
    base_f = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("stop0 frame_err", n_ferr - base_f, 1);
    chk("stop0 count", fifo_count, 0);

    // overflow on the fifth entry
    base_o = n_ovf;
    send_frame(8'h15, 0, 1, 0); sb.push_back({2'b00, 8'h15});
    send_frame(8'h1D, 0, 1, 0); sb.push_back({2'b00, 8'h1D});
    send_frame(8'h24, 0, 1, 0); sb.push_back({2'b00, 8'h24});
    send_frame(8'h2D, 0, 1, 0); sb.push_back({2'b00, 8'h2D});
    chk("fill count", fifo_count, 4);
    chk("fill no ovf", n_ovf - base_o, 0);
    send_frame(8'h2C, 0, 1, 0);
    tick(2);
    chk("ovf pulse", n_ovf - base_o, 1);
    chk("ovf count", fifo_count, 4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf pop%0d", i));
    chk("ovf drained", key_valid, 0);

    // push and pop together while full
    base_o = n_ovf;
    send_frame(8'h15, 0, 1, 0); sb.push_back({2'b00, 8'h15});
    send_frame(8'h1D, 0, 1, 0); sb.push_back({2'b00, 8'h1D});
    send_frame(8'h24, 0, 1, 0); sb.push_back({2'b00, 8'h24});
    send_frame(8'h2D, 0, 1, 0); sb.push_back({2'b00, 8'h2D});
    send_frame(8'h2C, 0, 1, 1); sb.push_back({2'b00, 8'h2C});
    tick(2);
    chk("simul no ovf", n_ovf - base_o, 0);
    chk("simul count", fifo_count, 4);
    for (int i = 0; i < 4; i++) pop_check($sformatf("simul pop%0d", i));

    // timeout: start + 5 data bits, then clk_kb idles high
    base_f = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    tick(TO + FL + 20);
    chk("tmo pulses", n_ferr - base_f, 1);
    chk("tmo delay", ferr_cyc - last_fall, FL + 2 + TO);
    chk("tmo count", fifo_count, 0);
    send_frame(8'h1C, 0, 1, 0); sb.push_back({2'b00, 8'h1C});
    pop_check("after tmo");

    // reset mid-frame drops the frame and the pending break flag
    send_frame(8'hF0, 0, 1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b0;
    tick(2);
    chk("midrst valid", key_valid, 0);
    chk("midrst count", fifo_count, 0);
    reset = 1'b1;
    tick(5);
    send_frame(8'h1C, 0, 1, 0); sb.push_back({2'b00, 8'h1C});
    pop_check("after midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
